// File: rtl/dense_ctrl.sv
// rtl/dense_ctrl.sv - fully-connected layer sequencer: RAM read issue, MAC strobe alignment, scale/saturate writeback.
// Optional saturation counters enabled by DENSE_CTRL_SAT_STATS_EN.
module dense_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 7,
    parameter int IN_DIM     = 1568,
    parameter int OUT_DIM    = 10,
    parameter int READ_LAT   = 2,
    parameter int ACCW       = 43,
    localparam int IW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1,
    localparam int WW = (IN_DIM * OUT_DIM > 1) ? $clog2(IN_DIM * OUT_DIM) : 1,
    localparam int OW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [IW-1:0]         in_addr,
    output logic [WW-1:0]         w_addr,
    output logic [OW-1:0]         bias_addr,
    output logic                  mac_en,
    output logic                  mac_first,
    output logic                  mac_last,
    input  logic                  acc_valid,
    input  logic [ACCW-1:0]       acc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OW-1:0]         out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [31:0]           sat_pos_cnt,
    output logic [31:0]           sat_neg_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_FINISH} state_t;

    localparam logic [IW-1:0] I_LAST = IW'(IN_DIM - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUT_DIM - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(2 ** (DATA_WIDTH - 1)));
    localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                  state_q, state_d;
    logic [OW-1:0]           o_q, o_d;
    logic [IW-1:0]           i_q, i_d;
    logic [WW-1:0]           w_q, w_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [READ_LAT-1:0]     pv_q, pv_d, pf_q, pf_d, pl_q, pl_d;
    logic signed [ACCW-1:0]  sh;
    logic                    clip_pos, clip_neg, capture;

    always_comb begin
        state_d    = state_q;
        o_d        = o_q;
        i_d        = i_q;
        w_d        = w_q;
        out_data_d = out_data_q;
        rd_en      = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        capture    = 1'b0;
        busy       = (state_q != S_IDLE);
        sh         = $signed(acc) >>> FRAC_BITS;
        clip_pos   = (sh > SAT_MAX);
        clip_neg   = (sh < SAT_MIN);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    o_d     = '0;
                    i_d     = '0;
                    w_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rd_en = 1'b1;
                w_d   = w_q + WW'(1);
                if (i_q == I_LAST) state_d = S_DRAIN;
                else               i_d = i_q + IW'(1);
            end
            S_DRAIN: begin
                if (acc_valid) begin
                    capture    = 1'b1;
                    out_data_d = clip_pos ? OUT_MAX : (clip_neg ? OUT_MIN : sh[DATA_WIDTH-1:0]);
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (o_q == O_LAST) begin
                        state_d = S_FINISH;
                    end else begin
                        o_d     = o_q + OW'(1);
                        i_d     = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d    = S_IDLE;
            capture    = 1'b0;
            out_data_d = out_data_q;
        end
    end

    // Strobes ride a READ_LAT-deep shift so they line up with RAM read data.
    always_comb begin
        pv_d[0] = rd_en;
        pf_d[0] = rd_en && (i_q == '0);
        pl_d[0] = rd_en && (i_q == I_LAST);
        for (int k = 1; k < READ_LAT; k++) begin
            pv_d[k] = pv_q[k-1];
            pf_d[k] = pf_q[k-1];
            pl_d[k] = pl_q[k-1];
        end
        if (abort) begin
            pv_d = '0;
            pf_d = '0;
            pl_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            o_q        <= '0;
            i_q        <= '0;
            w_q        <= '0;
            out_data_q <= '0;
            pv_q       <= '0;
            pf_q       <= '0;
            pl_q       <= '0;
        end else begin
            state_q    <= state_d;
            o_q        <= o_d;
            i_q        <= i_d;
            w_q        <= w_d;
            out_data_q <= out_data_d;
            pv_q       <= pv_d;
            pf_q       <= pf_d;
            pl_q       <= pl_d;
        end
    end

    assign in_addr   = i_q;
    assign w_addr    = w_q;
    assign bias_addr = o_q;
    assign out_addr  = o_q;
    assign out_data  = out_data_q;
    assign mac_en    = pv_q[READ_LAT-1];
    assign mac_first = pf_q[READ_LAT-1];
    assign mac_last  = pl_q[READ_LAT-1];

`ifdef DENSE_CTRL_SAT_STATS_EN
    logic [31:0] pos_cnt_q, pos_cnt_d, neg_cnt_q, neg_cnt_d;

    always_comb begin
        pos_cnt_d = pos_cnt_q;
        neg_cnt_d = neg_cnt_q;
        if (capture && clip_pos && (pos_cnt_q != '1)) pos_cnt_d = pos_cnt_q + 32'd1;
        if (capture && clip_neg && (neg_cnt_q != '1)) neg_cnt_d = neg_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_cnt_q <= '0;
            neg_cnt_q <= '0;
        end else begin
            pos_cnt_q <= pos_cnt_d;
            neg_cnt_q <= neg_cnt_d;
        end
    end

    assign sat_pos_cnt = pos_cnt_q;
    assign sat_neg_cnt = neg_cnt_q;
`else
    assign sat_pos_cnt = 32'd0;
    assign sat_neg_cnt = 32'd0;
`endif
endmodule
